// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-and-add multiplier with a start/done handshake.
// One partial product is accumulated per clock. The latency is fixed at
// WIDTH CALC cycles plus one DONE cycle.
// Optional macro SEQ_MULTIPLIER_SIGNED_EN treats a and b as two's complement.
// In that mode the operand magnitudes are multiplied and the sign is applied
// when DONE is entered.
module seq_multiplier #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  logic sgn;

  // |v| for a two's complement operand. The most negative value maps onto
  // its unsigned magnitude, which still fits in WIDTH bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? WIDTH'(~v + WIDTH'(1)) : v;
  endfunction

  // Re-apply the result sign to the unsigned magnitude product.
  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v,
                                               input logic          neg);
    return neg ? PW'(-v) : v;
  endfunction
`endif

  // A new operation may start from IDLE or in the DONE cycle (back-to-back).
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == CALC) && (cnt == CNT_W'(WIDTH - 1));

  // Add this iteration's partial product when the current multiplier bit is set.
  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = acc + (PW'(mcand) << cnt);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register. busy and done are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == CALC);
      done  <= (state_nxt == DONE);
    end
  end

  // Operand capture, iteration and result update.
  // product changes only when DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      sgn     <= 1'b0;
`endif
    end else if (accept) begin
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      mcand  <= magnitude(a);
      mplier <= magnitude(b);
      sgn    <= a[WIDTH-1] ^ b[WIDTH-1];
`else
      mcand  <= a;
      mplier <= b;
`endif
      acc    <= '0;
      cnt    <= '0;
    end else if (state == CALC) begin
      acc    <= acc_nxt;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        product <= apply_sign(acc_nxt, sgn);
`else
        product <= acc_nxt;
`endif
      end
    end
  end

endmodule
